regfile_scoreboard: RTL and testbench
=====================================

# regfile_scoreboard

Parametrised multi-read-port integer register file with write-to-read bypass, hardwired zero register and a per-register busy scoreboard for the pipelined RISC-V core. It sits in the decode stage: writeback drives the write port, decode reads operands and marks destinations busy on issue, and hazard logic uses the busy flags to stall. It replaces the fixed 2-read, 64-bit, negedge-write register file.

## Interface
- XLEN, 64, register width in bits
- NREGS, 32, number of architectural registers (power of two, ≥ 2)
- NRD, 2, number of read ports (1..4)
- AW, $clog2(NREGS), address width (derived; not overridden)
- CW, $clog2(NREGS)+1, pending-count width (derived)

- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- rs_addr  in  NRD*AW  read addresses; port i = bits [i*AW +: AW]
- rd_data  out  NRD*XLEN  read data per port, combinational
- rs_busy  out  NRD  per port: operand still pending (unresolved hazard)
- wr_en  in  1  writeback strobe
- wr_addr  in  AW  writeback destination
- wr_data  in  XLEN  writeback value
- issue_en  in  1  instruction issued with a destination register
- issue_addr  in  AW  destination of the issued instruction
- flush  in  1  pipeline flush: drop all outstanding busy marks
- pending_cnt  out  CW  number of registers currently busy (registered)

## Operation
- Storage: NREGS × XLEN flops; busy vector NREGS bits.
- Register 0: always reads 0; writes to it discarded; never marked busy.
- Write: at rising edge when wr_en=1 and wr_addr≠0, reg[wr_addr] ← wr_data.
- Read port i: if rs_addr_i=0 → 0; else if wr_en=1 and wr_addr=rs_addr_i → wr_data (bypass); else reg[rs_addr_i].
- rs_busy_i = busy[rs_addr_i] AND NOT (wr_en AND wr_addr=rs_addr_i); always 0 for address 0.
- Busy update per edge, in priority order:
  - flush=1: all busy bits ← 0; issue_en ignored this cycle; wr_en writes data normally.
  - else issue_en=1, issue_addr≠0: busy[issue_addr] ← 1 (set beats clear when wr_addr=issue_addr in the same cycle — new producer).
  - wr_en=1, wr_addr≠0, not being set: busy[wr_addr] ← 0.
- pending_cnt ← popcount of the next busy vector; equals popcount(busy) one edge after any change.
- Writeback to a non-busy register is legal (data written, busy stays 0).

## Timing
- Reset (reset=0, asynchronous): all registers ← 0, busy ← 0, pending_cnt ← 0; rd_data reads 0 during reset; rs_busy = 0.
- Reset deassertion synchronous to clk by the caller; first write accepted on the first rising edge after release.
- Read latency 0 cycles (combinational from rs_addr, wr_*).
- Write visible via bypass in the same cycle, from storage from the next cycle.
- Busy set by issue at edge N → rs_busy high from cycle N+1 until the cycle writeback asserts (low in that cycle by bypass).
- pending_cnt: 1-cycle latency, max value NREGS−1; no wrap possible.
- Reset mid-operation: all state cleared immediately regardless of pending issue/writeback.

## Structure
- Shared core package: XLEN default, register-count default, ZERO_REG index constant, regaddr_t typedef.
- One natural sub-module: regfile_read_port (address decode, zero check, bypass mux, busy qualify), instantiated NRD times in a generate loop.
- Popcount implemented inline as a function; no separate module.

## Test plan
- Reset: hold reset=0 with prior random writes → all rd_data=0, rs_busy=0, pending_cnt=0 after release.
- Write/read: wr x5←0xDEAD_BEEF_0000_0001; same cycle rs_addr0=5 → bypass value; next cycle still reads it; write x0←0xFF → x0 reads 0.
- Scoreboard: issue x7 at edge 1 → rs_busy=1 on a port reading x7, pending_cnt=1; wr x7 at cycle 4 → rs_busy=0 that cycle, pending_cnt=0 next cycle.
- Simultaneous: issue_addr=wr_addr=9 same cycle → data written, busy[9] stays 1, pending_cnt unchanged.
- Flush: mark x1,x2,x3 busy, then flush with issue_en=1 on x4 → all busy 0, pending_cnt=0, x4 not busy.
- Parameters: NRD=4, XLEN=32, NREGS=16 → four independent ports, each bypassing and busy-checking correctly, pending_cnt saturates at 15 after issuing x1..x15.

Source files
------------

// File: rtl/regfile_scoreboard_pkg.sv
// Shared core constants and types for the decode-stage register file
// and busy scoreboard.
package regfile_scoreboard_pkg;

    localparam int XLEN_DEFAULT  = 64;
    localparam int NREGS_DEFAULT = 32;
    localparam int ZERO_REG      = 0;

    typedef logic [$clog2(NREGS_DEFAULT)-1:0] regaddr_t;

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Operand-read, writeback, issue and flush signals between the pipeline
// (master) and the register file / scoreboard (slave).
interface regfile_scoreboard_if
    import regfile_scoreboard_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int NREGS = NREGS_DEFAULT,
    parameter int NRD   = 2
);
    localparam int AW = $clog2(NREGS);
    localparam int CW = $clog2(NREGS) + 1;

    logic [NRD*AW-1:0]   rs_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rs_busy;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [XLEN-1:0]     wr_data;
    logic                issue_en;
    logic [AW-1:0]       issue_addr;
    logic                flush;
    logic [CW-1:0]       pending_cnt;

    modport master (
        output rs_addr, wr_en, wr_addr, wr_data, issue_en, issue_addr, flush,
        input  rd_data, rs_busy, pending_cnt
    );

    modport slave (
        input  rs_addr, wr_en, wr_addr, wr_data, issue_en, issue_addr, flush,
        output rd_data, rs_busy, pending_cnt
    );

endinterface

// File: rtl/regfile_scoreboard_read_port.sv
// One operand read port: register select, zero-register check, same-cycle
// writeback bypass and busy qualification.
module regfile_read_port
    import regfile_scoreboard_pkg::*;
#(
    parameter int   XLEN  = XLEN_DEFAULT,
    parameter int   NREGS = NREGS_DEFAULT,
    localparam int  AW    = $clog2(NREGS)
)
(
    input  logic [AW-1:0]               rs_addr,
    input  logic [NREGS-1:0][XLEN-1:0]  regs,
    input  logic [NREGS-1:0]            busy,
    input  logic                        wr_en,
    input  logic [AW-1:0]               wr_addr,
    input  logic [XLEN-1:0]             wr_data,
    output logic [XLEN-1:0]             rd_data,
    output logic                        rs_busy
);

    logic is_zero;
    logic wr_hit;

    assign is_zero = (rs_addr == AW'(ZERO_REG));
    assign wr_hit  = wr_en && (wr_addr == rs_addr);

    // A writeback landing this cycle both supplies the data and resolves the hazard.
    always_comb begin
        rd_data = regs[rs_addr];
        rs_busy = busy[rs_addr] && !wr_hit;
        if (is_zero) begin
            rd_data = '0;
            rs_busy = 1'b0;
        end else if (wr_hit) begin
            rd_data = wr_data;
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port integer register file with write-to-read bypass, hardwired
// x0 and a per-register busy scoreboard with a registered pending count.
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int   XLEN  = XLEN_DEFAULT,
    parameter int   NREGS = NREGS_DEFAULT,
    parameter int   NRD   = 2,
    localparam int  AW    = $clog2(NREGS),
    localparam int  CW    = $clog2(NREGS) + 1
)
(
    input  logic                 clk,
    input  logic                 reset,
    regfile_scoreboard_if.slave  bus
);

    logic [NREGS-1:0][XLEN-1:0] regs;
    logic [NREGS-1:0]           busy;
    logic [NREGS-1:0]           busy_next;
    logic [CW-1:0]              pending_q;
    logic                       wr_live;
    logic                       wr_real;
    logic                       issue_real;

    function automatic logic [CW-1:0] popcount(input logic [NREGS-1:0] v);
        logic [CW-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < NREGS; i++) begin
            cnt = cnt + CW'(v[i]);
        end
        return cnt;
    endfunction

    // Bypass is suppressed while reset is held so every port reads zero.
    assign wr_live    = bus.wr_en && reset;
    assign wr_real    = bus.wr_en && (bus.wr_addr != AW'(ZERO_REG));
    assign issue_real = bus.issue_en && (bus.issue_addr != AW'(ZERO_REG));

    // Register storage; x0 is never written so it stays zero from reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regs <= '0;
        end else if (wr_real) begin
            regs[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Next busy vector: flush wins, then a new producer's set beats the writeback clear.
    always_comb begin
        busy_next = busy;
        if (bus.flush) begin
            busy_next = '0;
        end else begin
            if (wr_real) begin
                busy_next[bus.wr_addr] = 1'b0;
            end
            if (issue_real) begin
                busy_next[bus.issue_addr] = 1'b1;
            end
        end
        busy_next[ZERO_REG] = 1'b0;
    end

    // Scoreboard state and its population count, updated together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy      <= '0;
            pending_q <= '0;
        end else begin
            busy      <= busy_next;
            pending_q <= popcount(busy_next);
        end
    end

    assign bus.pending_cnt = pending_q;

    for (genvar i = 0; i < NRD; i++) begin : g_port
        regfile_read_port #(
            .XLEN  (XLEN),
            .NREGS (NREGS)
        ) u_port (
            .rs_addr (bus.rs_addr[i*AW +: AW]),
            .regs    (regs),
            .busy    (busy),
            .wr_en   (wr_live),
            .wr_addr (bus.wr_addr),
            .wr_data (bus.wr_data),
            .rd_data (bus.rd_data[i*XLEN +: XLEN]),
            .rs_busy (bus.rs_busy[i])
        );
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: a default 64-bit/32-reg/2-port
// instance and a 32-bit/16-reg/4-port instance share clock and reset.
module tb_regfile_scoreboard;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    regfile_scoreboard_if #(.XLEN(64), .NREGS(32), .NRD(2)) bus64 ();
    regfile_scoreboard_if #(.XLEN(32), .NREGS(16), .NRD(4)) bus32 ();

    regfile_scoreboard #(.XLEN(64), .NREGS(32), .NRD(2)) dut64 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus64)
    );

    regfile_scoreboard #(.XLEN(32), .NREGS(16), .NRD(4)) dut32 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus32)
    );

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drop all strobes on both instances; read addresses are left alone.
    task automatic idle_all();
        bus64.wr_en = 1'b0; bus64.issue_en = 1'b0; bus64.flush = 1'b0;
        bus32.wr_en = 1'b0; bus32.issue_en = 1'b0; bus32.flush = 1'b0;
    endtask

    task automatic test_reset();
        bus64.wr_en = 1'b1; bus64.wr_addr = 5'd3; bus64.wr_data = 64'h1234_5678;
        bus64.issue_en = 1'b1; bus64.issue_addr = 5'd6;
        bus32.wr_en = 1'b1; bus32.wr_addr = 4'd2; bus32.wr_data = 32'hCAFE;
        bus32.issue_en = 1'b1; bus32.issue_addr = 4'd5;
        step();
        idle_all();
        reset = 1'b0;
        bus64.rs_addr = {5'd6, 5'd3};
        bus32.rs_addr = {4'd0, 4'd0, 4'd5, 4'd2};
        #1;
        checks++;
        if (bus64.rd_data[63:0] !== 64'h0) begin
            errors++; $display("[TB] FAIL reset_rd64: got %h expected 0", bus64.rd_data[63:0]);
        end
        checks++;
        if (bus64.rs_busy !== 2'b00) begin
            errors++; $display("[TB] FAIL reset_busy64: got %b expected 00", bus64.rs_busy);
        end
        checks++;
        if (bus32.rd_data[31:0] !== 32'h0 || bus32.rs_busy !== 4'b0000) begin
            errors++; $display("[TB] FAIL reset_port32: got data %h busy %b expected 0/0000", bus32.rd_data[31:0], bus32.rs_busy);
        end
        bus64.wr_en = 1'b1; bus64.wr_addr = 5'd3; bus64.wr_data = 64'hFF;
        #1;
        checks++;
        if (bus64.rd_data[63:0] !== 64'h0) begin
            errors++; $display("[TB] FAIL reset_no_bypass: got %h expected 0", bus64.rd_data[63:0]);
        end
        bus64.wr_en = 1'b0;
        step();
        reset = 1'b1;
        #1;
        checks++;
        if (bus64.pending_cnt !== 6'd0 || bus32.pending_cnt !== 5'd0) begin
            errors++; $display("[TB] FAIL reset_pending: got %0d/%0d expected 0/0", bus64.pending_cnt, bus32.pending_cnt);
        end
        checks++;
        if (bus64.rd_data[127:64] !== 64'h0 || bus64.rs_busy !== 2'b00) begin
            errors++; $display("[TB] FAIL reset_release: got data %h busy %b expected 0/00", bus64.rd_data[127:64], bus64.rs_busy);
        end
    endtask

    task automatic test_write_read();
        bus64.rs_addr = {5'd0, 5'd5};
        bus64.wr_en = 1'b1; bus64.wr_addr = 5'd5; bus64.wr_data = 64'hDEAD_BEEF_0000_0001;
        #1;
        checks++;
        if (bus64.rd_data[63:0] !== 64'hDEAD_BEEF_0000_0001) begin
            errors++; $display("[TB] FAIL wr_bypass: got %h expected deadbeef00000001", bus64.rd_data[63:0]);
        end
        step();
        idle_all();
        #1;
        checks++;
        if (bus64.rd_data[63:0] !== 64'hDEAD_BEEF_0000_0001) begin
            errors++; $display("[TB] FAIL wr_storage: got %h expected deadbeef00000001", bus64.rd_data[63:0]);
        end
        bus64.rs_addr = {5'd0, 5'd0};
        bus64.wr_en = 1'b1; bus64.wr_addr = 5'd0; bus64.wr_data = 64'hFF;
        #1;
        checks++;
        if (bus64.rd_data !== 128'h0) begin
            errors++; $display("[TB] FAIL x0_bypass: got %h expected 0", bus64.rd_data);
        end
        step();
        idle_all();
        #1;
        checks++;
        if (bus64.rd_data[63:0] !== 64'h0 || bus64.pending_cnt !== 6'd0) begin
            errors++; $display("[TB] FAIL x0_write: got %h cnt %0d expected 0/0", bus64.rd_data[63:0], bus64.pending_cnt);
        end
    endtask

    task automatic test_scoreboard();
        bus64.rs_addr = {5'd7, 5'd0};
        bus64.issue_en = 1'b1; bus64.issue_addr = 5'd7;
        #1;
        checks++;
        if (bus64.rs_busy[1] !== 1'b0) begin
            errors++; $display("[TB] FAIL issue_same_cycle: got %b expected 0", bus64.rs_busy[1]);
        end
        step();
        idle_all();
        #1;
        checks++;
        if (bus64.rs_busy[1] !== 1'b1 || bus64.pending_cnt !== 6'd1) begin
            errors++; $display("[TB] FAIL issue_busy: got busy %b cnt %0d expected 1/1", bus64.rs_busy[1], bus64.pending_cnt);
        end
        step();
        step();
        bus64.wr_en = 1'b1; bus64.wr_addr = 5'd7; bus64.wr_data = 64'h77;
        #1;
        checks++;
        if (bus64.rs_busy[1] !== 1'b0 || bus64.rd_data[127:64] !== 64'h77) begin
            errors++; $display("[TB] FAIL wb_resolve: got busy %b data %h expected 0/77", bus64.rs_busy[1], bus64.rd_data[127:64]);
        end
        checks++;
        if (bus64.pending_cnt !== 6'd1) begin
            errors++; $display("[TB] FAIL wb_cnt_lag: got %0d expected 1", bus64.pending_cnt);
        end
        step();
        idle_all();
        #1;
        checks++;
        if (bus64.pending_cnt !== 6'd0 || bus64.rs_busy[1] !== 1'b0) begin
            errors++; $display("[TB] FAIL wb_clear: got cnt %0d busy %b expected 0/0", bus64.pending_cnt, bus64.rs_busy[1]);
        end
    endtask

    task automatic test_simultaneous();
        bus64.rs_addr = {5'd0, 5'd9};
        bus64.issue_en = 1'b1; bus64.issue_addr = 5'd9;
        step();
        idle_all();
        bus64.issue_en = 1'b1; bus64.issue_addr = 5'd9;
        bus64.wr_en = 1'b1; bus64.wr_addr = 5'd9; bus64.wr_data = 64'h99;
        #1;
        checks++;
        if (bus64.rs_busy[0] !== 1'b0 || bus64.rd_data[63:0] !== 64'h99) begin
            errors++; $display("[TB] FAIL simul_bypass: got busy %b data %h expected 0/99", bus64.rs_busy[0], bus64.rd_data[63:0]);
        end
        step();
        idle_all();
        #1;
        checks++;
        if (bus64.rs_busy[0] !== 1'b1 || bus64.pending_cnt !== 6'd1 || bus64.rd_data[63:0] !== 64'h99) begin
            errors++; $display("[TB] FAIL simul_set_wins: got busy %b cnt %0d data %h expected 1/1/99", bus64.rs_busy[0], bus64.pending_cnt, bus64.rd_data[63:0]);
        end
        bus64.wr_en = 1'b1; bus64.wr_addr = 5'd9; bus64.wr_data = 64'h9A;
        step();
        idle_all();
        #1;
        checks++;
        if (bus64.pending_cnt !== 6'd0) begin
            errors++; $display("[TB] FAIL simul_cleanup: got %0d expected 0", bus64.pending_cnt);
        end
    endtask

    task automatic test_flush();
        bus64.rs_addr = {5'd1, 5'd4};
        for (int i = 1; i <= 3; i++) begin
            bus64.issue_en = 1'b1; bus64.issue_addr = 5'(i);
            step();
        end
        idle_all();
        #1;
        checks++;
        if (bus64.pending_cnt !== 6'd3 || bus64.rs_busy !== 2'b10) begin
            errors++; $display("[TB] FAIL flush_setup: got cnt %0d busy %b expected 3/10", bus64.pending_cnt, bus64.rs_busy);
        end
        bus64.flush = 1'b1;
        bus64.issue_en = 1'b1; bus64.issue_addr = 5'd4;
        bus64.wr_en = 1'b1; bus64.wr_addr = 5'd2; bus64.wr_data = 64'h22;
        step();
        idle_all();
        #1;
        checks++;
        if (bus64.pending_cnt !== 6'd0 || bus64.rs_busy !== 2'b00) begin
            errors++; $display("[TB] FAIL flush_clear: got cnt %0d busy %b expected 0/00", bus64.pending_cnt, bus64.rs_busy);
        end
        bus64.rs_addr = {5'd3, 5'd2};
        #1;
        checks++;
        if (bus64.rs_busy !== 2'b00 || bus64.rd_data[63:0] !== 64'h22) begin
            errors++; $display("[TB] FAIL flush_write: got busy %b data %h expected 00/22", bus64.rs_busy, bus64.rd_data[63:0]);
        end
    endtask

    task automatic test_params();
        bus32.rs_addr = {4'd10, 4'd3, 4'd0, 4'd10};
        bus32.wr_en = 1'b1; bus32.wr_addr = 4'd10; bus32.wr_data = 32'hA5A5_0001;
        #1;
        checks++;
        if (bus32.rd_data !== {32'hA5A5_0001, 32'h0, 32'h0, 32'hA5A5_0001}) begin
            errors++; $display("[TB] FAIL p4_bypass: got %h expected a5a50001_00000000_00000000_a5a50001", bus32.rd_data);
        end
        step();
        idle_all();
        #1;
        checks++;
        if (bus32.rd_data[127:96] !== 32'hA5A5_0001) begin
            errors++; $display("[TB] FAIL p4_storage: got %h expected a5a50001", bus32.rd_data[127:96]);
        end
        for (int i = 1; i < 16; i++) begin
            bus32.issue_en = 1'b1; bus32.issue_addr = 4'(i);
            step();
        end
        idle_all();
        bus32.rs_addr = {4'd15, 4'd12, 4'd5, 4'd1};
        #1;
        checks++;
        if (bus32.pending_cnt !== 5'd15 || bus32.rs_busy !== 4'b1111) begin
            errors++; $display("[TB] FAIL p4_all_busy: got cnt %0d busy %b expected 15/1111", bus32.pending_cnt, bus32.rs_busy);
        end
        bus32.wr_en = 1'b1; bus32.wr_addr = 4'd12; bus32.wr_data = 32'h0C0C;
        #1;
        checks++;
        if (bus32.rs_busy !== 4'b1011 || bus32.rd_data[95:64] !== 32'h0C0C) begin
            errors++; $display("[TB] FAIL p4_port_resolve: got busy %b data %h expected 1011/0c0c", bus32.rs_busy, bus32.rd_data[95:64]);
        end
        step();
        idle_all();
        #1;
        checks++;
        if (bus32.pending_cnt !== 5'd14) begin
            errors++; $display("[TB] FAIL p4_cnt_dec: got %0d expected 14", bus32.pending_cnt);
        end
        bus32.issue_en = 1'b1; bus32.issue_addr = 4'd12;
        step();
        bus32.issue_addr = 4'd3;
        step();
        idle_all();
        #1;
        checks++;
        if (bus32.pending_cnt !== 5'd15) begin
            errors++; $display("[TB] FAIL p4_cnt_max: got %0d expected 15", bus32.pending_cnt);
        end
        bus32.flush = 1'b1;
        step();
        idle_all();
    endtask

    // Run every scenario in order, then report.
    initial begin
        reset = 1'b0;
        bus64.rs_addr = '0; bus64.wr_addr = '0; bus64.wr_data = '0; bus64.issue_addr = '0;
        bus32.rs_addr = '0; bus32.wr_addr = '0; bus32.wr_data = '0; bus32.issue_addr = '0;
        idle_all();
        step();
        reset = 1'b1;
        step();
        test_reset();
        test_write_read();
        test_scoreboard();
        test_simultaneous();
        test_flush();
        test_params();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
